// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - address map, state and target encodings shared by the MIO responder.
package mio_pkg;

    localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR     = 32'hE000_0000;
    localparam logic [31:0] SW_ADDR      = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR     = 32'hF000_0004;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [2:0] {
        T_RAM,
        T_LED,
        T_SW,
        T_CNT,
        T_ERR
    } target_t;

    // Misalignment, unmapped addresses and switch writes all collapse to T_ERR.
    function automatic target_t decode(input logic [31:0] addr, input logic we,
                                       input int unsigned ram_depth);
        logic [33:0] lim;
        logic [33:0] off;
        lim = 34'(ram_depth) << 2;
        off = {2'b00, addr} - {2'b00, RAM_BASE};
        if (addr[1:0] != 2'b00) return T_ERR;
        if (off < lim)          return T_RAM;
        if (addr == LED_ADDR)   return T_LED;
        if (addr == SW_ADDR)    return we ? T_ERR : T_SW;
        if (addr == CNT_ADDR)   return T_CNT;
        return T_ERR;
    endfunction

endpackage

// File: rtl/mio_bus_responder_if.sv
// rtl/mio_bus_responder_if.sv - CPU memory/IO request and response signals.
interface mio_bus_responder_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        bus_err;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, bus_err
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, bus_err
    );

endinterface

// File: rtl/mio_ram.sv
// rtl/mio_ram.sv - single-port synchronous word RAM, no reset.
module mio_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - CPU memory/IO responder: RAM with wait states, LED, switches, counter.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int          RAM_DEPTH = 1024,
    parameter int          RAM_LAT   = 2,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 16,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    mio_bus_responder_if.slave   bus,
    input  logic [SW_W-1:0]      sw_in,
    output logic [LED_W-1:0]     led_out,
    output logic [31:0]          cnt_out
);

    localparam int         AW        = $clog2(RAM_DEPTH);
    localparam logic [3:0] WAIT_INIT = (RAM_LAT > 0) ? 4'(RAM_LAT - 1) : 4'd0;

    state_t            state_q, state_d;
    target_t           tgt_now, tgt_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [AW-1:0]     idx_q;
    logic [3:0]        wait_q;
    logic [LED_W-1:0]  led_q;
    logic [31:0]       cnt_q;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [31:0]       ram_rdata;
    logic              wr_resp;

    assign tgt_now = decode(bus.cpu_addr, bus.cpu_we, RAM_DEPTH);
    assign wr_resp = (state_q == RESP) && we_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    state_d = (tgt_now == T_RAM && RAM_LAT > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request is captured on the accept edge; the bus inputs are ignored afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q   <= T_ERR;
            we_q    <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
        end else if (state_q == IDLE && bus.cpu_req) begin
            tgt_q   <= tgt_now;
            we_q    <= bus.cpu_we;
            wdata_q <= bus.cpu_wdata;
            idx_q   <= bus.cpu_addr[AW+1:2];
            wait_q  <= WAIT_INIT;
        end else if (state_q == WAIT && wait_q != 4'd0) begin
            wait_q  <= wait_q - 4'd1;
        end
    end

    // In IDLE the RAM is addressed straight from the bus so a zero-latency read lands in RESP.
    assign ram_addr = (state_q == IDLE) ? bus.cpu_addr[AW+1:2] : idx_q;
    assign ram_we   = wr_resp && (tgt_q == T_RAM);

    mio_ram #(
        .DEPTH (RAM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_resp && tgt_q == T_LED) begin
                led_q <= wdata_q[LED_W-1:0];
            end
            cnt_q <= (wr_resp && tgt_q == T_CNT) ? wdata_q : cnt_q + 32'd1;
        end
    end

    assign led_out = led_q;
    assign cnt_out = cnt_q;

    always_comb begin
        bus.cpu_ready = 1'b0;
        bus.bus_err   = 1'b0;
        bus.cpu_rdata = '0;
        if (state_q == RESP) begin
            bus.cpu_ready = 1'b1;
            case (tgt_q)
                T_RAM:   bus.cpu_rdata = ram_rdata;
                T_LED:   bus.cpu_rdata = 32'(led_q);
                T_SW:    bus.cpu_rdata = 32'(sw_in);
                T_CNT:   bus.cpu_rdata = cnt_q;
                default: begin
                    bus.bus_err   = 1'b1;
                    bus.cpu_rdata = ERR_DATA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb/tb_mio_bus_responder.sv - directed scoreboard bench for mio_bus_responder.
module tb_mio_bus_responder;
    import mio_pkg::*;

    localparam int RAM_LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        chk_rd;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw  = '0;
    logic [15:0] led;
    logic [31:0] cnt;
    int          compared   = 0;
    int          mismatched = 0;
    exp_t        sb[$];

    mio_bus_responder_if bus ();

    mio_bus_responder #(
        .RAM_DEPTH (1024),
        .RAM_LAT   (RAM_LAT),
        .LED_W     (16),
        .SW_W      (16),
        .ERR_DATA  (32'hDEAD_BEEF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .sw_in   (sw),
        .led_out (led),
        .cnt_out (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                          input string tag);
        exp_t e;
        int   cyc;
        e.rdata  = exp_rd;
        e.err    = exp_err;
        e.lat    = exp_lat;
        e.chk_rd = !we || exp_err;
        e.tag    = tag;
        @(posedge clk); #1;
        sb.push_back(e);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus.cpu_ready && cyc < 20);
        bus.cpu_req = 1'b0;
        e = sb.pop_front();
        if (!bus.cpu_ready) begin
            compared++;
            mismatched++;
            $error("FAIL %s_timeout: observed no cpu_ready after %0d cycles expected within %0d", e.tag, cyc, e.lat);
        end else begin
            chk({e.tag, "_lat"}, 32'(cyc), 32'(e.lat));
            chk({e.tag, "_err"}, 32'(bus.bus_err), 32'(e.err));
            if (e.chk_rd) chk({e.tag, "_rdata"}, bus.cpu_rdata, e.rdata);
        end
    endtask

    initial begin
        int seen_ready;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_err",   32'(bus.bus_err),   32'd0);
        chk("rst_rdata", bus.cpu_rdata,      32'd0);
        chk("rst_led",   32'(led),           32'd0);
        chk("rst_cnt",   cnt,                32'd0);
        rst = 1'b0;

        access(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,         1'b0, 1 + RAM_LAT, "ram_wr");
        access(1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 1 + RAM_LAT, "ram_rd");

        access(1'b1, 32'hE000_0000, 32'h0000_A5A5, 32'h0,         1'b0, 1, "led_wr");
        @(posedge clk); #1;
        chk("led_out", 32'(led), 32'h0000_A5A5);
        access(1'b0, 32'hE000_0000, 32'h0,         32'h0000_A5A5, 1'b0, 1, "led_rd");

        sw = 16'h00FF;
        access(1'b0, 32'hF000_0000, 32'h0,         32'h0000_00FF, 1'b0, 1, "sw_rd");
        access(1'b1, 32'hF000_0000, 32'h1111_2222, 32'hDEAD_BEEF, 1'b1, 1, "sw_wr");

        access(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 32'h0,         1'b0, 1, "cnt_wr");
        @(posedge clk); #1;
        chk("cnt_loaded", cnt, 32'hFFFF_FFFE);
        access(1'b0, 32'hF000_0004, 32'h0,         32'h0000_0000, 1'b0, 1, "cnt_wrap");

        access(1'b0, 32'h0000_0006, 32'h0,         32'hDEAD_BEEF, 1'b1, 1, "misalign_rd");
        access(1'b0, 32'h8000_0000, 32'h0,         32'hDEAD_BEEF, 1'b1, 1, "unmapped_rd");
        access(1'b1, 32'h0000_0012, 32'h0000_5555, 32'hDEAD_BEEF, 1'b1, 1, "misalign_wr");
        access(1'b1, 32'hE000_0002, 32'h0000_0F0F, 32'hDEAD_BEEF, 1'b1, 1, "led_misalign_wr");
        access(1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 1 + RAM_LAT, "ram_keep");
        access(1'b0, 32'hE000_0000, 32'h0,         32'h0000_A5A5, 1'b0, 1, "led_keep");

        access(1'b1, 32'h0000_0040, 32'h1111_1111, 32'h0,         1'b0, 1 + RAM_LAT, "ram_pre");
        @(posedge clk); #1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h0000_0040;
        bus.cpu_wdata = 32'hCAFE_0000;
        @(posedge clk); #1;
        chk("wait_entered", 32'(dut.state_q), 32'(WAIT));
        rst = 1'b1;
        #1;
        chk("rstw_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rstw_state", 32'(dut.state_q),   32'(IDLE));
        chk("rstw_led",   32'(led),           32'd0);
        chk("rstw_cnt",   cnt,                32'd0);
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        seen_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_ready) seen_ready++;
        end
        chk("rstw_no_ready", 32'(seen_ready), 32'd0);
        access(1'b0, 32'h0000_0040, 32'h0,         32'h1111_1111, 1'b0, 1 + RAM_LAT, "ram_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
